// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
// Imported by clk_div_ctrl and div_period_cnt.
package clk_div_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int unsigned DIV_MIN = 2;

    // High-phase length: ceil(n/2), odd ratios favour the high phase.
    function automatic logic [31:0] hi_len(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/div_period_cnt.sv
// Wrap counter for one output period: runs 0..N-1 and wraps to 0.
// Exposes the next count so the parent can register its outputs.
module div_period_cnt
    import clk_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_cnt_nxt,
    output logic             o_last
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign o_last = (cnt_q == i_n - WIDTH'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_last ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        cnt_q <= cnt_d;
    end

    assign o_cnt     = cnt_q;
    assign o_cnt_nxt = cnt_d;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: FSM, ratio handshake and registered output decode.
// A new ratio only takes effect on a period boundary.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_div_valid,
    output logic             o_div_ready,
    output logic             o_div_err,
    output logic             o_clk,
    output logic             o_tick
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             last;
    logic             xfer;
    logic             legal;
    logic             run_d;

    div_period_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .i_clk     (i_clk),
        .i_clr     (cnt_clr | i_rst),
        .i_en      (cnt_en),
        .i_n       (div_q),
        .o_cnt     (cnt),
        .o_cnt_nxt (cnt_nxt),
        .o_last    (last)
    );

    assign xfer  = i_div_valid && ready_q;
    assign legal = 32'(i_div) >= DIV_MIN;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        err_d   = xfer && !legal;
        unique case (state_q)
            STOP: begin
                cnt_clr = 1'b1;
                if (xfer && legal) div_d = i_div;
                if (i_en) state_d = RUN;
            end
            RUN: begin
                if (!i_en) begin
                    // Enable drop wins: a same-cycle ratio applies directly.
                    cnt_clr = 1'b1;
                    state_d = STOP;
                    if (xfer && legal) div_d = i_div;
                end else begin
                    cnt_en = 1'b1;
                    if (xfer && legal) begin
                        pend_d  = i_div;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (!i_en) begin
                    cnt_clr = 1'b1;
                    div_d   = pend_q;
                    state_d = STOP;
                end else begin
                    cnt_en = 1'b1;
                    if (last) begin
                        div_d   = pend_q;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = STOP;
            end
        endcase
    end

    // Outputs are registered from next-state values, so they line up with cnt.
    assign run_d   = (state_d != STOP);
    assign clk_d   = run_d && (32'(cnt_nxt) < hi_len(32'(div_d)));
    assign tick_d  = run_d && (cnt_nxt == '0);
    assign ready_d = (state_d != PEND);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= STOP;
            div_q   <= WIDTH'(DEFAULT_DIV);
            pend_q  <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign o_clk       = clk_q;
    assign o_tick      = tick_q;
    assign o_div_err   = err_q;
    assign o_div_ready = ready_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: directed scenarios then random traffic,
// checked cycle by cycle against a behavioural period model.
module tb_clk_div_ctrl;

    localparam int WIDTH = 8;
    localparam int DEF   = 7;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_en;
    logic [WIDTH-1:0] i_div;
    logic             i_div_valid;
    logic             o_div_ready;
    logic             o_div_err;
    logic             o_clk;
    logic             o_tick;

    clk_div_ctrl #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEF)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_div       (i_div),
        .i_div_valid (i_div_valid),
        .o_div_ready (o_div_ready),
        .o_div_err   (o_div_err),
        .o_clk       (o_clk),
        .o_tick      (o_tick)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic clk;
        logic tick;
        logic err;
        logic ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model state: running flag, pending request, ratio, position.
    bit m_run;
    bit m_pend;
    int m_n;
    int m_p;
    int m_pos;
    bit m_ready = 1'b0;

    always @(posedge i_clk) begin
        exp_t e;
        bit   xfer;
        bit   ok;
        int   d;
        d    = int'(i_div);
        xfer = i_div_valid && m_ready;
        ok   = d >= 2;
        e    = '0;
        if (i_rst) begin
            m_run  = 0;
            m_pend = 0;
            m_n    = DEF;
            m_p    = 0;
            m_pos  = 0;
        end else begin
            e.err = xfer && !ok;
            if (!m_run) begin
                if (xfer && ok) m_n = d;
                if (i_en) begin
                    m_run = 1;
                    m_pos = 0;
                end
            end else if (!i_en) begin
                if (m_pend) m_n = m_p;
                else if (xfer && ok) m_n = d;
                m_run  = 0;
                m_pend = 0;
                m_pos  = 0;
            end else begin
                if (m_pend && m_pos == m_n - 1) begin
                    m_n    = m_p;
                    m_pend = 0;
                    m_pos  = 0;
                end else begin
                    if (!m_pend && xfer && ok) begin
                        m_pend = 1;
                        m_p    = d;
                    end
                    m_pos = (m_pos + 1) % m_n;
                end
            end
            e.clk   = m_run && (m_pos < (m_n + 1) / 2);
            e.tick  = m_run && (m_pos == 0);
            e.ready = !m_pend;
        end
        m_ready = e.ready;
        exp_q.push_back(e);
    end

    task automatic cmp(input string nm, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, req);
        end
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("o_clk", o_clk, e.clk);
            cmp("o_tick", o_tick, e.tick);
            cmp("o_div_err", o_div_err, e.err);
            cmp("o_div_ready", o_div_ready, e.ready);
        end
    end

    task automatic drive(input bit rst, input bit en, input bit vld,
                         input int div, input int cyc);
        for (int k = 0; k < cyc; k++) begin
            i_rst       = rst;
            i_en        = en;
            i_div_valid = vld;
            i_div       = WIDTH'(div);
            @(posedge i_clk);
            #1;
            i_div_valid = 1'b0;
        end
    endtask

    initial begin
        i_rst       = 1'b1;
        i_en        = 1'b0;
        i_div       = '0;
        i_div_valid = 1'b0;
        drive(1, 0, 0, 0, 3);
        // Default ratio run; request 4 mid-period.
        drive(0, 1, 0, 0, 16);
        drive(0, 1, 0, 0, 2);
        drive(0, 1, 1, 4, 1);
        drive(0, 1, 0, 0, 20);
        // Stop, load 3 directly, restart.
        drive(0, 0, 0, 0, 3);
        drive(0, 0, 1, 3, 1);
        drive(0, 1, 0, 0, 12);
        // Illegal ratios while running.
        drive(1, 0, 0, 0, 2);
        drive(0, 1, 0, 0, 5);
        drive(0, 1, 1, 1, 1);
        drive(0, 1, 0, 0, 2);
        drive(0, 1, 1, 0, 1);
        drive(0, 1, 0, 0, 10);
        // Request on the period boundary.
        drive(1, 0, 0, 0, 2);
        drive(0, 1, 0, 0, 7);
        drive(0, 1, 1, 5, 1);
        drive(0, 1, 0, 0, 25);
        // Drop enable in PEND, re-enable, then reset mid-period.
        drive(0, 1, 0, 0, 3);
        drive(0, 1, 1, 6, 1);
        drive(0, 0, 0, 0, 3);
        drive(0, 1, 0, 0, 15);
        drive(1, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 10);
        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            bit rst;
            bit en;
            bit vld;
            int div;
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 39) != 0);
            vld = ($urandom_range(0, 5) == 0);
            div = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1)
                                              : $urandom_range(2, 12);
            if ($urandom_range(0, 49) == 0) div = $urandom_range(2, 255);
            drive(rst, en, vld, div, 1);
        end
        drive(0, 0, 0, 0, 3);
        @(negedge i_clk);
        @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable clock-divider controller for the board-level clock generation path. It derives a divided clock-style output and a one-cycle period tick from the system clock by an integer ratio. The ratio can be reprogrammed through a valid/ready handshake, and a new ratio is applied only on a period boundary, so no output period is ever truncated. It replaces a fixed compile-time divide constant wherever the GPIO clock output must change rate without a reset.

## Interface

Parameters:
- WIDTH, 8, width of the divide ratio and of the internal period counter.
- DEFAULT_DIV, 7, ratio loaded at reset; must satisfy 2 ≤ DEFAULT_DIV ≤ 2^WIDTH−1.

Ports:
- i_clk  in  1  system clock (CLOCK_50 domain); the only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  run enable; low stops the output.
- i_div  in  WIDTH  requested divide ratio N.
- i_div_valid  in  1  request strobe for i_div.
- o_div_ready  out  1  controller can accept i_div this cycle.
- o_div_err  out  1  one-cycle pulse, accepted ratio was illegal (0 or 1) and was discarded.
- o_clk  out  1  divided output, registered.
- o_tick  out  1  one-cycle pulse on the first cycle of every output period, registered.

## Operation

- Ratio register `div_q` holds the active ratio N. Counter `cnt` runs 0..N−1 and wraps to 0.
- While running, o_clk = 1 for `cnt` < H and 0 otherwise, where H = N − N/2 (ceil(N/2)). Odd N therefore gives the extra cycle to the high phase.
- o_tick = 1 exactly when `cnt` == 0 while running.
- A transfer occurs on any cycle with i_div_valid && o_div_ready.
- A ratio of 0 or 1 is illegal. The transfer still completes, o_div_err pulses on the next cycle, and there is no state change.
- FSM states:
  - STOP: o_clk = 0, o_tick = 0, `cnt` held at 0, o_div_ready = 1. A legal transfer loads `div_q` directly. If i_en = 1, go to RUN.
  - RUN: counting, o_div_ready = 1. A legal transfer latches the ratio into `div_pend` and moves to PEND. If i_en = 0, go to STOP, which zeroes o_clk immediately.
  - PEND: counting with the old N, o_div_ready = 0. On the cycle where `cnt` == N−1, load `div_q` from `div_pend`, wrap `cnt` to 0, and return to RUN. If i_en = 0, load `div_pend` into `div_q` and go to STOP.
- If a transfer and the period boundary land on the same cycle in RUN, the request is latched into PEND. It applies at the next boundary, not the current one.
- If the i_en falling edge and a transfer land on the same cycle in RUN, the transfer is treated as in STOP: `div_q` is loaded and the state is STOP.

## Timing

- Reset values: state STOP, `div_q` = DEFAULT_DIV, `cnt` = 0, o_clk = 0, o_tick = 0, o_div_err = 0, `div_pend` = 0.
- o_div_ready = 0 while i_rst is high. It equals 1 on the first cycle after reset is released.
- Start latency is one cycle. i_en is sampled high in STOP, and on the next cycle o_clk = 1, o_tick = 1, `cnt` = 0.
- Stop latency is one cycle. i_en is sampled low, and on the next cycle o_clk = 0.
- Output period is exactly N i_clk cycles: H high, N/2 low.
- Ratio change latency runs from the accepting edge to the start of the first period at the new N. That is the remaining cycles of the current period plus one.
- Reset asserted mid-PEND discards `div_pend` and restores DEFAULT_DIV on the next edge.
- All outputs are flop outputs. There is no combinational path from inputs to o_clk or o_tick. o_div_ready is decoded from state only.

## Structure

- Shared package `clk_div_pkg`:
  - the FSM state enum (STOP, RUN, PEND);
  - the constant DIV_MIN = 2;
  - a function returning the high-phase length H for a given N.
- One natural sub-module, `div_period_cnt`: the WIDTH-bit wrap counter.
  - Inputs: load/clear, enable, N.
  - Outputs: `cnt`, `last` (`cnt` == N−1).
- The FSM, handshake and output decode stay in `clk_div_ctrl`.

## Test plan

- Reset then i_en = 1 with DEFAULT_DIV = 7: o_clk shows 4 high, 3 low repeating, and o_tick pulses every 7 cycles. The first tick comes one cycle after i_en is sampled.
- In RUN, send i_div = 4 at `cnt` = 2: o_div_ready drops for the rest of that period. The old 7-cycle period completes intact, then the output runs 2 high, 2 low.
- In STOP, send i_div = 3, then raise i_en: the first period is already 2 high, 1 low, with no PEND visit.
- Send i_div = 1, then i_div = 0, while running: each produces an o_div_err pulse on the following cycle. The output period stays at 7 and o_div_ready stays 1.
- Send i_div = 5 on the same cycle as `cnt` = 6: the current period ends at 7, one more 7-cycle period follows, and then 5-cycle periods begin.
- Drop i_en in PEND holding 6, then re-enable: o_clk = 0 one cycle after i_en falls, and after re-enable the periods are 6 (3 high, 3 low). Assert i_rst mid-period: all outputs read 0 the next cycle and the ratio returns to 7.
